// File: rtl/mct_scheduler.sv
// Memory-cycle scheduler: at each T12 boundary picks the next MCT type
// (instruction, counter increment, interrupt entry or monitor halt).
module mct_scheduler #(
  parameter int NCNT     = 8,
  parameter int SELW     = 3,
  parameter int MAXBURST = 4
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            t12,
  input  logic            gojam,
  input  logic [NCNT-1:0] cntreq,
  input  logic            intreq,
  input  logic            inhint,
  input  logic            extend,
  input  logic            mstp,
  input  logic            mstrtp,
  output logic            cyc_inst,
  output logic            cyc_pinc,
  output logic            cyc_rupt,
  output logic            cyc_stop,
  output logic [SELW-1:0] cntsel,
  output logic [NCNT-1:0] cntack,
  output logic            ruptack,
  output logic            stopped
);

  // state   | meaning
  // ST_INST | normal instruction MCT
  // ST_PINC | counter-increment MCT for line cntsel
  // ST_RUPT | interrupt-entry MCT
  // ST_HALT | monitor halt, MCT unused

  typedef enum logic [1:0] {ST_INST, ST_PINC, ST_RUPT, ST_HALT} state_t;

  localparam logic [3:0] MAXB = 4'(MAXBURST);

  state_t          state_q, state_d;
  state_t          arb_st, t12_st;
  logic [3:0]      burst_q, burst_d;
  logic [SELW-1:0] cntsel_q, cntsel_d;
  logic [NCNT-1:0] cntack_q, cntack_d;
  logic            ruptack_q, ruptack_d;
  logic            step_pend_q, step_pend_d;

  logic [NCNT-1:0] served;
  logic [NCNT-1:0] masked;
  logic [SELW-1:0] low_idx;
  logic            rupt_ok;
  logic            halt_hold;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INST;
      burst_q     <= '0;
      cntsel_q    <= '0;
      cntack_q    <= '0;
      ruptack_q   <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      cntsel_q    <= cntsel_d;
      cntack_q    <= cntack_d;
      ruptack_q   <= ruptack_d;
      step_pend_q <= step_pend_d;
    end
  end

  // The line being acked at this edge is excluded so it is never re-selected.
  always_comb begin
    served = '0;
    if (state_q == ST_PINC) served[cntsel_q] = 1'b1;
    masked = cntreq & ~served;
    low_idx = '0;
    for (int i = NCNT - 1; i >= 0; i--) begin
      if (masked[i]) low_idx = SELW'(i);
    end
  end

  always_comb begin
    rupt_ok   = intreq && !inhint && !extend && (state_q != ST_RUPT);
    halt_hold = mstp && !((state_q == ST_HALT) && step_pend_q);

    if ((masked != '0) && (burst_q < MAXB)) arb_st = ST_PINC;
    else if (rupt_ok)                        arb_st = ST_RUPT;
    else                                     arb_st = ST_INST;

    t12_st = halt_hold ? ST_HALT : arb_st;
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    cntsel_d    = cntsel_q;
    cntack_d    = '0;
    ruptack_d   = 1'b0;
    step_pend_d = step_pend_q;

    if (gojam) begin
      state_d     = ST_INST;
      burst_d     = '0;
      step_pend_d = 1'b0;
    end else begin
      if (t12) begin
        cntack_d  = served;
        ruptack_d = (state_q == ST_RUPT);
        state_d   = t12_st;
        if (t12_st == ST_PINC) begin
          cntsel_d = low_idx;
          burst_d  = (burst_q == MAXB) ? burst_q : 4'(burst_q + 4'd1);
        end else begin
          burst_d = '0;
        end
        if ((state_q == ST_HALT) && (t12_st != ST_HALT)) step_pend_d = 1'b0;
      end
      // A new step request at the exit edge is kept for the next halt.
      if (mstrtp) step_pend_d = 1'b1;
    end
  end

  assign cyc_inst = (state_q == ST_INST);
  assign cyc_pinc = (state_q == ST_PINC);
  assign cyc_rupt = (state_q == ST_RUPT);
  assign cyc_stop = (state_q == ST_HALT);
  assign stopped  = cyc_stop;
  assign cntsel   = cntsel_q;
  assign cntack   = cntack_q;
  assign ruptack  = ruptack_q;

endmodule

// File: tb/tb_mct_scheduler.sv
// Bench for mct_scheduler: directed scenarios with literal expectations plus
// randomized MCT traffic checked every cycle against a behavioural model.
module tb_mct_scheduler;

  localparam int NCNT = 8;
  localparam int SELW = 3;
  localparam int MAXBURST = 4;
  localparam int C_INST = 0, C_PINC = 1, C_RUPT = 2, C_HALT = 3;

  logic clock = 1'b0;
  logic rst = 1'b0;
  logic t12 = 1'b0, gojam = 1'b0, intreq = 1'b0, inhint = 1'b0, extend = 1'b0;
  logic mstp = 1'b0, mstrtp = 1'b0;
  logic [NCNT-1:0] cntreq = '0;
  logic cyc_inst, cyc_pinc, cyc_rupt, cyc_stop, ruptack, stopped;
  logic [SELW-1:0] cntsel;
  logic [NCNT-1:0] cntack;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mct_scheduler #(.NCNT(NCNT), .SELW(SELW), .MAXBURST(MAXBURST)) dut (
    .clock(clock), .rst(rst), .t12(t12), .gojam(gojam), .cntreq(cntreq),
    .intreq(intreq), .inhint(inhint), .extend(extend), .mstp(mstp),
    .mstrtp(mstrtp), .cyc_inst(cyc_inst), .cyc_pinc(cyc_pinc),
    .cyc_rupt(cyc_rupt), .cyc_stop(cyc_stop), .cntsel(cntsel),
    .cntack(cntack), .ruptack(ruptack), .stopped(stopped)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NCNT-1:0] v);
    for (int i = 0; i < NCNT; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: cycle type as an integer, burst as a plain count.
  int m_cyc = C_INST;
  int m_sel = 0;
  int m_burst = 0;
  bit m_step = 1'b0;
  logic [NCNT-1:0] m_cntack = '0;
  bit m_ruptack = 1'b0;

  always @(posedge clock or negedge rst) begin : model
    int nxt;
    logic [NCNT-1:0] avail;
    bit nstep;
    if (!rst) begin
      m_cyc <= C_INST; m_sel <= 0; m_burst <= 0; m_step <= 1'b0;
      m_cntack <= '0; m_ruptack <= 1'b0;
    end else if (gojam) begin
      m_cyc <= C_INST; m_burst <= 0; m_step <= 1'b0;
      m_cntack <= '0; m_ruptack <= 1'b0;
    end else begin
      nstep = m_step;
      m_cntack <= '0;
      m_ruptack <= 1'b0;
      if (t12) begin
        avail = cntreq;
        if (m_cyc == C_PINC) begin
          m_cntack <= NCNT'(1) << m_sel;
          avail[m_sel] = 1'b0;
        end
        m_ruptack <= (m_cyc == C_RUPT);
        if (mstp && (m_cyc != C_HALT || !m_step)) nxt = C_HALT;
        else if (avail != 0 && m_burst < MAXBURST) nxt = C_PINC;
        else if (intreq && !inhint && !extend && m_cyc != C_RUPT) nxt = C_RUPT;
        else nxt = C_INST;
        if (nxt == C_PINC) begin
          m_sel <= lowest(avail);
          m_burst <= m_burst + 1;
        end else begin
          m_burst <= 0;
        end
        if (m_cyc == C_HALT && nxt != C_HALT) nstep = 1'b0;
        m_cyc <= nxt;
      end
      if (mstrtp) nstep = 1'b1;
      m_step <= nstep;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_onehot", 32'({cyc_inst, cyc_pinc, cyc_rupt, cyc_stop}),
            32'({m_cyc == C_INST, m_cyc == C_PINC, m_cyc == C_RUPT, m_cyc == C_HALT}));
      check("cntsel", 32'(cntsel), 32'(m_sel));
      check("cntack", 32'(cntack), 32'(m_cntack));
      check("ruptack", 32'(ruptack), 32'(m_ruptack));
      check("stopped", 32'(stopped), 32'(m_cyc == C_HALT));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic t12_edge();
    t12 = 1'b1;
    tick();
    t12 = 1'b0;
  endtask

  int acks;

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b1;
    tick();

    // idle running
    for (int k = 0; k < 3; k++) begin
      t12_edge();
      check("idle_inst", 32'(cyc_inst), 32'd1);
      check("idle_ack", 32'({cntack, ruptack}), 32'd0);
      repeat (2) tick();
    end

    // two requesters, each dropped on its ack
    cntreq = 8'b0000_0110;
    t12_edge();
    check("req_pinc1", 32'({cyc_pinc, cntsel}), 32'h9);
    repeat (2) tick();
    t12_edge();
    check("req_ack1", 32'(cntack), 32'h02);
    check("req_pinc2", 32'({cyc_pinc, cntsel}), 32'hA);
    cntreq = 8'b0000_0100;
    tick();
    check("ack_one_clk", 32'(cntack), 32'h00);
    tick();
    t12_edge();
    check("req_ack2", 32'(cntack), 32'h04);
    check("req_inst", 32'(cyc_inst), 32'd1);
    cntreq = '0;
    repeat (2) tick();

    // burst limit with two lines held
    cntreq = 8'h03;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      t12_edge();
      if (cntack != '0) acks++;
      check("burst_pat", 32'(cyc_pinc), 32'((k % 5) != 4));
      repeat (2) tick();
    end
    check("burst_acks", 32'(acks), 32'd8);
    cntreq = '0;
    t12_edge();
    repeat (2) tick();

    // interrupt gated by INHINT, never back-to-back
    intreq = 1'b1;
    inhint = 1'b1;
    for (int k = 0; k < 2; k++) begin
      t12_edge();
      check("rupt_inh", 32'(cyc_inst), 32'd1);
      repeat (2) tick();
    end
    inhint = 1'b0;
    t12_edge();
    check("rupt_entry", 32'(cyc_rupt), 32'd1);
    repeat (2) tick();
    t12_edge();
    check("rupt_ack", 32'(ruptack), 32'd1);
    check("rupt_no_b2b", 32'(cyc_inst), 32'd1);
    intreq = 1'b0;
    tick();
    check("rupt_ack_clr", 32'(ruptack), 32'd0);
    tick();

    // monitor halt and single step
    mstp = 1'b1;
    t12_edge();
    check("halt_enter", 32'({cyc_stop, stopped}), 32'h3);
    repeat (2) tick();
    t12_edge();
    check("halt_hold", 32'(cyc_stop), 32'd1);
    mstrtp = 1'b1;
    tick();
    mstrtp = 1'b0;
    t12_edge();
    check("step_inst", 32'(cyc_inst), 32'd1);
    repeat (2) tick();
    t12_edge();
    check("step_rehalt", 32'(cyc_stop), 32'd1);
    mstp = 1'b0;
    repeat (2) tick();
    t12_edge();
    check("halt_exit", 32'({cyc_inst, stopped}), 32'h2);
    repeat (2) tick();

    // GOJAM beats T12, then async reset mid-MCT
    cntreq = 8'h04;
    t12_edge();
    check("gj_pinc", 32'(cyc_pinc), 32'd1);
    repeat (2) tick();
    gojam = 1'b1;
    t12_edge();
    gojam = 1'b0;
    check("gj_inst", 32'(cyc_inst), 32'd1);
    check("gj_noack", 32'(cntack), 32'd0);
    repeat (2) tick();
    t12_edge();
    repeat (2) tick();
    t12_edge();
    check("pre_rst_ack", 32'(cntack), 32'h04);
    cntreq = '0;
    rst = 1'b0;
    #1;
    check("rst_out", 32'({cyc_inst, cyc_pinc, cyc_rupt, cyc_stop, stopped, ruptack}), 32'h20);
    check("rst_sel_ack", 32'({cntsel, cntack}), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) cntreq = NCNT'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) intreq = 1'($urandom);
      if ($urandom_range(0, 3) == 0) inhint = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) extend = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) mstp = ~mstp;
      gojam = ($urandom_range(0, 40) == 0);
      mstrtp = ($urandom_range(0, 20) == 0);
      t12 = 1'b1;
      tick();
      t12 = 1'b0;
      gojam = 1'b0;
      mstrtp = 1'b0;
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        mstrtp = ($urandom_range(0, 12) == 0);
        if ($urandom_range(0, 60) == 0) gojam = 1'b1;
        if ($urandom_range(0, 700) == 0) rst = 1'b0;
        tick();
        mstrtp = 1'b0;
        gojam = 1'b0;
        rst = 1'b1;
      end
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
